// File: rtl/matrix_frame_scheduler.sv
// Pixel write-port sequencer for the LED matrix driver chain.
// Host byte frames always take priority; the built-in test pattern fills one
// frame per pattern period, but only while the host is idle and the pattern
// is enabled.
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | waiting for a host start-of-frame byte or a pattern tick
// HOST_FRAME   | host frame in progress, pixels written as bytes arrive
// PATTERN_FILL | one pattern pixel per cycle, host stalled by host_ready=0
module matrix_frame_scheduler #(
    parameter int BOARDS            = 3,
    parameter int ROWS              = 4,
    parameter int OUTPUTS_PER_BOARD = 16,
    parameter int TIMEOUT_CYCLES    = 1000000,
    parameter int PATTERN_PERIOD    = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    input  logic       host_sof,
    output logic       host_ready,
    input  logic       pattern_enable,
    output logic [8:0] address_out,
    output logic [7:0] data_out,
    output logic       write_strobe_out,
    output logic       frame_done,
    output logic       host_active,
    output logic       protocol_error
);

    localparam int N  = BOARDS * OUTPUTS_PER_BOARD * ROWS;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(PATTERN_PERIOD + 1);

    localparam logic [8:0]    LAST_ADDR = 9'(N - 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PER_LOAD  = PW'(PATTERN_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        HOST_FRAME   = 2'd1,
        PATTERN_FILL = 2'd2
    } state_t;

    state_t        state;
    logic [8:0]    pix_cnt;
    logic [7:0]    phase;
    logic [TW-1:0] tmo_rem;
    logic [PW-1:0] per_rem;
    logic          accept;
    logic          per_tick;

    assign accept      = host_valid && host_ready;
    assign per_tick    = (per_rem == '0);
    // Remaining-cycles view of the idle timer: zero means the host has gone quiet.
    assign host_active = (tmo_rem != '0);

    // Host idle timer: reloads on every accepted byte, counts down and sticks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_rem <= '0;
        end else if (accept) begin
            tmo_rem <= TMO_LOAD;
        end else if (tmo_rem != '0) begin
            tmo_rem <= tmo_rem - TW'(1);
        end
    end

    // Free-running pattern period timer; the tick is the cycle it reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_rem <= PER_LOAD;
        end else if (per_tick) begin
            per_rem <= PER_LOAD;
        end else begin
            per_rem <= per_rem - PW'(1);
        end
    end

    // Frame sequencing FSM with registered write port and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            pix_cnt          <= '0;
            phase            <= '0;
            address_out      <= '0;
            data_out         <= '0;
            write_strobe_out <= 1'b0;
            frame_done       <= 1'b0;
            protocol_error   <= 1'b0;
            host_ready       <= 1'b0;
        end else begin
            write_strobe_out <= 1'b0;
            frame_done       <= 1'b0;
            protocol_error   <= 1'b0;
            host_ready       <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (host_sof) begin
                            address_out      <= '0;
                            data_out         <= host_data;
                            write_strobe_out <= 1'b1;
                            pix_cnt          <= 9'd1;
                            state            <= HOST_FRAME;
                        end else begin
                            // Mid-frame byte with no frame open: drop it.
                            protocol_error <= 1'b1;
                        end
                    end else if (!host_active && pattern_enable && per_tick) begin
                        pix_cnt    <= '0;
                        host_ready <= 1'b0;
                        state      <= PATTERN_FILL;
                    end
                end

                HOST_FRAME: begin
                    if (accept) begin
                        write_strobe_out <= 1'b1;
                        data_out         <= host_data;
                        if (host_sof) begin
                            // Restart: the new frame overwrites from pixel 0.
                            protocol_error <= 1'b1;
                            address_out    <= '0;
                            pix_cnt        <= 9'd1;
                        end else begin
                            address_out <= pix_cnt;
                            if (pix_cnt == LAST_ADDR) begin
                                frame_done <= 1'b1;
                                pix_cnt    <= '0;
                                state      <= IDLE;
                            end else begin
                                pix_cnt <= pix_cnt + 9'd1;
                            end
                        end
                    end else if (!host_active) begin
                        // Host stalled mid-frame; abandon it, keep what was written.
                        protocol_error <= 1'b1;
                        pix_cnt        <= '0;
                        state          <= IDLE;
                    end
                end

                PATTERN_FILL: begin
                    write_strobe_out <= 1'b1;
                    address_out      <= pix_cnt;
                    data_out         <= pix_cnt[7:0] + phase;
                    if (pix_cnt == LAST_ADDR) begin
                        frame_done <= 1'b1;
                        phase      <= phase + 8'd1;
                        pix_cnt    <= '0;
                        state      <= IDLE;
                    end else begin
                        pix_cnt    <= pix_cnt + 9'd1;
                        host_ready <= 1'b0;
                    end
                end

                default: begin
                    pix_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Scoreboard bench for matrix_frame_scheduler: the stimulus side pushes the
// expected write (address, data, frame_done, cycle) for each issued byte or
// pattern pixel; a monitor pops and compares on every write strobe.
module tb_matrix_frame_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_sof;
    logic       host_ready;
    logic       pattern_enable;
    logic [8:0] address_out;
    logic [7:0] data_out;
    logic       write_strobe_out;
    logic       frame_done;
    logic       host_active;
    logic       protocol_error;

    matrix_frame_scheduler #(
        .BOARDS            (3),
        .ROWS              (4),
        .OUTPUTS_PER_BOARD (16),
        .TIMEOUT_CYCLES    (100),
        .PATTERN_PERIOD    (300)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .host_data        (host_data),
        .host_valid       (host_valid),
        .host_sof         (host_sof),
        .host_ready       (host_ready),
        .pattern_enable   (pattern_enable),
        .address_out      (address_out),
        .data_out         (data_out),
        .write_strobe_out (write_strobe_out),
        .frame_done       (frame_done),
        .host_active      (host_active),
        .protocol_error   (protocol_error)
    );

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
        logic       done;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   err_cnt    = 0;
    int   r          = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: compare every strobe against the scoreboard, count error pulses.
    initial begin
        exp_t e;
        logic prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_err = 1'b0;
            end else begin
                if (write_strobe_out) begin
                    compared++;
                    if (q.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_strobe: addr=%0d data=%02h cyc=%0d, none expected",
                                 address_out, data_out, cyc);
                    end else begin
                        e = q.pop_front();
                        if (address_out !== e.addr || data_out !== e.data ||
                            frame_done !== e.done || cyc != e.cyc) begin
                            mismatched++;
                            $display("FAIL write: got addr=%0d data=%02h done=%0b cyc=%0d, expected addr=%0d data=%02h done=%0b cyc=%0d",
                                     address_out, data_out, frame_done, cyc, e.addr, e.data, e.done, e.cyc);
                        end
                    end
                end else if (frame_done) begin
                    compared++;
                    mismatched++;
                    $display("FAIL stray_frame_done: frame_done=1 without strobe at cyc=%0d", cyc);
                end
                if (protocol_error) begin
                    err_cnt++;
                    compared++;
                    if (prev_err) begin
                        mismatched++;
                        $display("FAIL error_pulse_width: protocol_error high two cycles at cyc=%0d", cyc);
                    end
                end
                prev_err = protocol_error;
            end
        end
    end

    // Present one byte, wait (bounded) for ready, and record the expected write.
    task automatic send_byte(input logic [7:0] d, input logic s, input logic wr,
                             input logic [8:0] a, input logic dn);
        int n;
        n = 0;
        host_data  = d;
        host_sof   = s;
        host_valid = 1'b1;
        @(negedge clk);
        while (!host_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!host_ready) begin
            chk("host_ready_wait", 0, 1);
            host_valid = 1'b0;
            host_sof   = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (wr) q.push_back(exp_t'{a, d, dn, cyc});
        host_valid = 1'b0;
        host_sof   = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        host_data      = 8'h00;
        host_valid     = 1'b0;
        host_sof       = 1'b0;
        pattern_enable = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_address", 32'(address_out), 0);
        chk("reset_data", 32'(data_out), 0);
        chk("reset_strobe", 32'(write_strobe_out), 0);
        chk("reset_host_active", 32'(host_active), 0);
        chk("reset_host_ready", 32'(host_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(host_ready), 1);
        chk("inactive_after_reset", 32'(host_active), 0);

        // Full host frame, one byte per cycle, data equals address.
        for (int k = 0; k < 192; k++)
            send_byte(8'(k), k == 0, 1'b1, 9'(k), k == 191);
        chk("host_active_in_frame", 32'(host_active), 1);
        chk("no_errors_full_frame", 32'(err_cnt), 0);

        // Stray byte in IDLE: dropped with an error pulse, no write.
        send_byte(8'h55, 1'b0, 1'b0, 9'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("stray_byte_error", 32'(err_cnt), 1);
        chk("stray_byte_no_write", 32'(q.size()), 0);

        // Partial frame restarted by a second sof.
        for (int k = 0; k < 100; k++)
            send_byte(8'(k + 3), k == 0, 1'b1, 9'(k), 1'b0);
        send_byte(8'hAA, 1'b1, 1'b1, 9'd0, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b1, 9'd1, 1'b0);
        chk("resync_sof_error", 32'(err_cnt), 2);

        // Host goes silent mid-frame: timeout aborts it.
        repeat (120) @(posedge clk);
        #1;
        chk("timeout_abort_error", 32'(err_cnt), 3);
        chk("timeout_host_inactive", 32'(host_active), 0);

        // Reset in the middle of a host frame.
        for (int k = 0; k < 50; k++)
            send_byte(8'(k) ^ 8'hC3, k == 0, 1'b1, 9'(k), 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset_address", 32'(address_out), 0);
        chk("midreset_data", 32'(data_out), 0);
        chk("midreset_strobe", 32'(write_strobe_out), 0);
        chk("midreset_ready", 32'(host_ready), 0);
        chk("midreset_host_active", 32'(host_active), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_byte(8'h11, 1'b1, 1'b1, 9'd0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b1, 9'd1, 1'b0);
        send_byte(8'h33, 1'b0, 1'b1, 9'd2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_frame_drained", 32'(q.size()), 0);
        chk("post_reset_no_error", 32'(err_cnt), 3);

        // Pattern frames: fresh reset so tick timing is known.
        rst            = 1'b1;
        pattern_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        r   = cyc;
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 192; k++)
                q.push_back(exp_t'{9'(k), 8'(k + j), k == 191, r + 301 + 300 * j + k});

        wait_cyc(r + 400);
        chk("fill_ready_low", 32'(host_ready), 0);
        chk("fill_host_inactive", 32'(host_active), 0);

        // Dropping the enable mid-fill must not cut the frame short.
        wait_cyc(r + 950);
        pattern_enable = 1'b0;
        wait_cyc(r + 1100);
        pattern_enable = 1'b1;

        // Host sof arrives at the 10th write of frame 3 and waits for the fill.
        wait_cyc(r + 1210);
        send_byte(8'hE7, 1'b1, 1'b1, 9'd0, 1'b0);
        pattern_enable = 1'b0;
        chk("host_accept_after_fill", 32'(cyc), 32'(r + 1393));

        wait_cyc(r + 1600);
        chk("final_timeout_error", 32'(err_cnt), 4);
        chk("final_queue_empty", 32'(q.size()), 0);
        chk("final_host_inactive", 32'(host_active), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
